// File: rtl/popcount19_gen_pkg.sv
// Shared constants, FSM state type and weight-class helpers
// for the popcount19 per-weight stimulus generator.
package popcount19_gen_pkg;

    localparam int N  = 19;
    localparam int WW = 5;
    localparam int IW = 17;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest N-bit vector of weight w: ones packed at the bottom
    function automatic logic [N-1:0] first_vec(input logic [WW-1:0] w);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[i] = (i < int'(w));
        return v;
    endfunction

    // Largest N-bit vector of weight w: ones packed at the top
    function automatic logic [N-1:0] last_vec(input logic [WW-1:0] w);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[i] = (i >= N - int'(w));
        return v;
    endfunction

endpackage

// File: rtl/popcount19_comb_next.sv
// Gosper successor: next larger N-bit vector with the same weight.
// Only meaningful when the input is not already the top of its class.
module popcount19_comb_next
    import popcount19_gen_pkg::*;
(
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_next
);

    logic [N:0]    w_xe;
    logic [N:0]    w_c;
    logic [N:0]    w_r;
    logic [N:0]    w_rx;
    logic [N-1:0]  w_t;
    logic [WW-1:0] w_ctz;

    assign w_xe = {1'b0, i_x};
    assign w_c  = w_xe & (-w_xe);
    assign w_r  = w_xe + w_c;
    assign w_rx = w_r ^ w_xe;
    assign w_t  = N'(w_rx >> 2);

    // Priority encoder: index of the lowest set bit
    always_comb begin
        w_ctz = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_x[i])
                w_ctz = WW'(i);
    end

    assign o_next = N'(w_r) | (w_t >> w_ctz);

endmodule

// File: rtl/popcount19_weight_gen.sv
// Emits every 19-bit vector of a requested weight, ascending,
// one per accepted beat, with valid/ready backpressure and abort.
module popcount19_weight_gen
    import popcount19_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [WW-1:0] cmd_weight,
    output logic          cmd_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_vec,
    output logic [WW-1:0] out_weight,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    input  logic          abort
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_vec;
    logic [WW-1:0] r_weight;
    logic [IW-1:0] r_index;
    logic          r_err;
    logic [N-1:0]  w_next;
    logic          w_cmd_hs;
    logic          w_cmd_ok;
    logic          w_beat;
    logic          w_last;

    popcount19_comb_next u_next (
        .i_x    (r_vec),
        .o_next (w_next)
    );

    // abort wins over a command presented in the same cycle
    assign w_cmd_hs = cmd_valid && (r_state == IDLE) && !abort;
    assign w_cmd_ok = w_cmd_hs && (cmd_weight <= WW'(N));
    assign w_beat   = (r_state == RUN) && out_ready;
    assign w_last   = (r_state == RUN) && (r_vec == last_vec(r_weight));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_cmd_ok) w_state_nxt = RUN;
            RUN:  if (abort || (w_beat && w_last)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec    <= '0;
            r_weight <= '0;
            r_index  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_cmd_hs && !w_cmd_ok;
            if (w_cmd_ok) begin
                r_vec    <= first_vec(cmd_weight);
                r_weight <= cmd_weight;
                r_index  <= '0;
            end else if (w_beat && !w_last && !abort) begin
                r_vec    <= w_next;
                r_index  <= r_index + IW'(1);
            end
        end
    end

    assign cmd_ready  = (r_state == IDLE);
    assign cmd_err    = r_err;
    assign out_valid  = (r_state == RUN);
    assign out_vec    = r_vec;
    assign out_weight = r_weight;
    assign out_index  = r_index;
    assign out_last   = w_last;

endmodule

// File: tb/tb_popcount19_weight_gen.sv
// Directed bench for popcount19_weight_gen: sequences per weight,
// backpressure, abort, illegal weight and async reset mid-run.
module tb_popcount19_weight_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_weight;
    logic        cmd_err;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_vec;
    logic [4:0]  out_weight;
    logic [16:0] out_index;
    logic        out_last;
    logic        abort;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    popcount19_weight_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_weight (cmd_weight),
        .cmd_err    (cmd_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .out_weight (out_weight),
        .out_index  (out_index),
        .out_last   (out_last),
        .abort      (abort)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [18:0] v,
                        input int idx, input logic last);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_vec"}, out_vec, v);
        check({tag, "_idx"}, out_index, idx);
        check({tag, "_last"}, out_last, last);
    endtask

    task automatic send_cmd(input logic [4:0] w);
        cmd_valid  = 1'b1;
        cmd_weight = w;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_vec"}, out_vec, 0);
        check({tag, "_idx"}, out_index, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_wt"}, out_weight, 0);
        check({tag, "_err"}, cmd_err, 0);
    endtask

    logic [18:0] w2_exp [11];
    logic [18:0] prev;
    int          cnt;
    int          bad_mono;
    int          bad_pop;
    int          n_last;
    logic        done;
    logic        found;

    initial begin
        w2_exp = '{19'h3, 19'h5, 19'h6, 19'h9, 19'hA, 19'hC,
                   19'h11, 19'h12, 19'h14, 19'h18, 19'h21};
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_weight = '0;
        out_ready  = 1'b1;
        abort      = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        step();

        // weight 0: one beat, first is last
        send_cmd(5'd0);
        @(negedge clk);
        beat("w0", 19'h0, 0, 1'b1);
        step();
        @(negedge clk);
        check("w0_end_valid", out_valid, 0);
        check("w0_end_ready", cmd_ready, 1);
        step();

        // weight 1: 19 back-to-back beats
        send_cmd(5'd1);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            beat("w1", 19'(1 << i), i, i == 18);
            step();
        end
        @(negedge clk);
        check("w1_end_valid", out_valid, 0);
        step();

        // weight 2 with backpressure, then abort at index 10
        send_cmd(5'd2);
        @(negedge clk);
        beat("w2_b0", w2_exp[0], 0, 1'b0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        beat("w2_hold1", w2_exp[1], 1, 1'b0);
        step();
        @(negedge clk);
        beat("w2_hold2", w2_exp[1], 1, 1'b0);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            beat("w2", w2_exp[i], i, 1'b0);
            if (i == 10) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_ready", cmd_ready, 1);
        step();

        // abort in IDLE discards a simultaneous command
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_weight = 5'd5;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_valid", out_valid, 0);
        check("abort_idle_err", cmd_err, 0);
        step();

        // weight 19: single full vector
        send_cmd(5'd19);
        @(negedge clk);
        beat("w19", 19'h7FFFF, 0, 1'b1);
        check("w19_wt", out_weight, 19);
        step();
        @(negedge clk);
        check("w19_end_valid", out_valid, 0);
        step();

        // weight 20: illegal, one-cycle error pulse
        send_cmd(5'd20);
        @(negedge clk);
        check("w20_err", cmd_err, 1);
        check("w20_valid", out_valid, 0);
        check("w20_ready", cmd_ready, 1);
        step();
        @(negedge clk);
        check("w20_err_clr", cmd_err, 0);
        check("w20_valid2", out_valid, 0);
        step();

        // weight 17: full sequence of C(19,17)=171 beats
        send_cmd(5'd17);
        cnt = 0; bad_mono = 0; bad_pop = 0; n_last = 0;
        prev = '0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (!out_valid) begin
                done = 1'b1;
            end else begin
                if (cnt == 0)
                    check("w17_first", out_vec, 19'h1FFFF);
                else if (out_vec <= prev)
                    bad_mono++;
                if ($countones(out_vec) != 17 || out_weight != 5'd17)
                    bad_pop++;
                if (out_index != 17'(cnt))
                    bad_mono++;
                if (out_last) begin
                    n_last++;
                    check("w17_last_vec", out_vec, 19'h7FFFC);
                    check("w17_last_idx", out_index, 170);
                end
                prev = out_vec;
                cnt++;
                step();
            end
        end
        check("w17_done", done, 1);
        check("w17_count", cnt, 171);
        check("w17_mono", bad_mono, 0);
        check("w17_pop", bad_pop, 0);
        check("w17_nlast", n_last, 1);
        step();

        // weight 9: async reset at index 500
        send_cmd(5'd9);
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (out_index == 17'd500) found = 1'b1;
            else step();
        end
        check("w9_reach500", found, 1);
        check("w9_pop", $countones(out_vec), 9);
        check("w9_wt", out_weight, 9);
        check("w9_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("w9_rst");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("w9_rst_ready", cmd_ready, 1);
        check("w9_rst_valid", out_valid, 0);
        step();

        send_cmd(5'd3);
        @(negedge clk);
        beat("w3", 19'h7, 0, 1'b0);
        check("w3_wt", out_weight, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("w3_abort_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount19_weight_gen.md
Name: popcount19_weight_gen

Overview:
Sequential stimulus generator for the 19-input popcount family. It is the inverse direction of a popcount: it takes a requested Hamming weight and emits every 19-bit vector with exactly that many ones, one vector per accepted beat, in ascending numeric order. It feeds exhaustive per-weight error characterisation (MAE/WCE per weight class) of the approximate popcount19 circuits in the same test harness.

Parameters:
N, 19, vector width (number of popcount inputs)
WW, 5, weight field width, ceil(log2(N+1))
IW, 17, beat index width, enough for max C(19,9)=92378

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  weight request valid
cmd_ready  out  1  high only in IDLE
cmd_weight  in  WW  requested weight, legal 0..N
cmd_err  out  1  one-cycle pulse: request with cmd_weight>N was accepted and dropped
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_vec  out  N  current vector, popcount exactly equal to weight
out_weight  out  WW  echo of the active weight
out_index  out  IW  beat sequence number, 0-based
out_last  out  1  high on the final vector of the sequence
abort  in  1  synchronous cancel of the running sequence

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready=1 after release; out_valid=0, out_vec=0, out_weight=0, out_index=0, out_last=0, cmd_err=0.
- States: IDLE, RUN.
- IDLE: cmd_ready=1. A handshake (cmd_valid&cmd_ready) with w<=N loads out_vec=(1<<w)-1, out_index=0, out_weight=w; next cycle state RUN, out_valid=1 (1-cycle latency). With w>N: cmd_err=1 for exactly one cycle, stay IDLE, out_valid stays 0.
- RUN: out_valid=1. out_vec/out_index/out_last/out_weight stay stable while out_valid&~out_ready (no beat dropped or changed under backpressure).
- On out_valid&out_ready with out_last=0: out_vec <= successor(out_vec), out_index <= out_index+1, no bubble (one beat per cycle when out_ready is held high).
- On out_valid&out_ready with out_last=1: next cycle IDLE, out_valid=0, cmd_ready=1.
- out_last is combinational from state: out_vec == ((1<<w)-1)<<(N-w). For w=0 and w=N the first beat is also the last.
- Successor (Gosper): c = x & -x; r = x + c; next = r | (((r ^ x) >> 2) >> ctz(x)). Evaluated at N+1 bits internally, truncated to N; the successor is only used when out_last=0, so the carry bit is never set. w=0: no successor is used.
- abort: in RUN, abort=1 forces IDLE on the next edge. out_valid=0 next cycle, even if a handshake occurs in the same cycle, and that beat counts as delivered. abort in IDLE is ignored, and abort overrides a simultaneous cmd handshake (the command is discarded).
- cmd_valid while in RUN: cmd_ready=0, and the request waits upstream.
- Reset mid-RUN: immediate return to reset values; no partial-sequence state survives.
- Invariant: popcount(out_vec)==out_weight whenever out_valid=1. Total beats per sequence = C(N,w).

Decomposition:
- Package popcount19_gen_pkg: N, WW, IW constants; state enum {IDLE, RUN}; function first_vec(w) and last_vec(w).
- One combinational sub-module, popcount19_comb_next: N-bit input x, N-bit successor output. It contains the lowest-set-bit isolation, add, XOR, the ctz priority encoder and the barrel right-shift. The top level holds the FSM, registers and handshake.

Test Plan:
- w=0, out_ready=1 -> exactly one beat out_vec=0x00000, out_index=0, out_last=1, then cmd_ready=1.
- w=1, out_ready=1 -> 19 consecutive beats 0x00001,0x00002,...,0x40000; out_last only at index 18; no idle cycles between beats.
- w=2, out_ready toggling 1,0,0,1 -> beats 0x00003,0x00005,0x00006 in order; out_vec and out_index held unchanged during low cycles.
- w=19 -> single beat 0x7FFFF with out_last=1. w=20 -> cmd_err pulses one cycle, out_valid never rises, cmd_ready stays 1.
- w=9 full run -> 92378 beats, strictly increasing, each with popcount 9; last beat 0x7FC00 at index 92377.
- w=9 with rst asserted at index 500 -> all outputs at reset values asynchronously. After release, new w=3 starts at 0x00007 with index 0. Also: abort at index 10 -> out_valid=0 next cycle, and the next command is accepted.
